// File: rtl/wb_cmd_master_pkg.sv
// Shared types and constants for the Wishbone command master.
// Holds the FSM state encoding, bus width constants and the default abort limit.
// No logic; imported by the top and the timeout counter.
package wb_cmd_master_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    // Width of the bus-cycle watchdog counter (limit range 1..65535).
    localparam int TMO_W = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/wb_tmo_counter.sv
// Bus-cycle watchdog: counts cycles while enabled and flags the cycle that reaches the limit.
// Latency: expired_o is combinational on the count, asserted in the limit-th enabled cycle.
// Backpressure: none; clear has priority over enable.
module wb_tmo_counter
    import wb_cmd_master_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [TMO_W-1:0] limit_i,
    output logic             expired_o
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    // Next count: restart on clear, otherwise advance once per enabled cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The enabled cycle in which the count would reach the limit is the expiring one,
    // so a limit of N keeps the bus cycle open for exactly N cycles.
    assign expired_o = enable_i && (({1'b0, cnt_q} + 17'd1) == {1'b0, limit_i});

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone initiator: turns one command into one classic bus cycle and returns one response.
// Latency: cyc/stb one edge after accept; response one edge after ack/err/timeout; 3-cycle minimum turnaround.
// Backpressure: cmd_ready_o low until the response is taken; response held while rsp_ready_i is low.
// Optional bus-cycle timeout is compiled in with `define WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [WB_AW-1:0] cmd_adr_i,
    input  logic [WB_DW-1:0] cmd_dat_i,
    input  logic [WB_SW-1:0] cmd_sel_i,
    input  logic             cmd_we_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WB_DW-1:0] rsp_dat_o,
    output logic             rsp_err_o,
    output logic             rsp_tmo_o,
    output logic [WB_AW-1:0] wb_adr_o,
    output logic [WB_DW-1:0] wb_dat_o,
    output logic [WB_SW-1:0] wb_sel_o,
    output logic             wb_we_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    input  logic [WB_DW-1:0] wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    output logic [15:0]      txn_cnt_o
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_tmo_range
        $error("wb_cmd_master: TIMEOUT_CYCLES must be within 1..65535");
    end

    state_e           state_q, state_d;
    logic [WB_AW-1:0] adr_q, adr_d;
    logic [WB_DW-1:0] dat_q, dat_d;
    logic [WB_SW-1:0] sel_q, sel_d;
    logic             we_q, we_d;
    logic [WB_DW-1:0] rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_tmo_q, rsp_tmo_d;
    logic [15:0]      txn_cnt_q, txn_cnt_d;
    logic             in_bus;
    logic             cmd_fire;
    logic             tmo_expired;

    assign in_bus   = (state_q == BUS);
    assign cmd_fire = cmd_valid_i && (state_q == IDLE);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    wb_tmo_counter u_tmo (
        .clk_i    (wb_clk_i),
        .rst_ni   (wb_rst_ni),
        .clear_i  (cmd_fire),
        .enable_i (in_bus),
        .limit_i  (TMO_LIMIT),
        .expired_o(tmo_expired)
    );
`else
    // Without the watchdog a bus cycle only ends on ack or err.
    assign tmo_expired = 1'b0;
`endif

    // Next-state and datapath: accept, run the bus cycle, then hold the response.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        rsp_tmo_d = rsp_tmo_q;
        txn_cnt_d = txn_cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    sel_d   = cmd_sel_i;
                    we_d    = cmd_we_i;
                    state_d = BUS;
                end
            end
            BUS: begin
                // err beats ack; either beats a watchdog expiring in the same cycle.
                if (wb_err_i) begin
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                    rsp_tmo_d = 1'b0;
                    state_d   = RESP;
                end else if (wb_ack_i) begin
                    rsp_dat_d = we_q ? '0 : wb_dat_i;
                    rsp_err_d = 1'b0;
                    rsp_tmo_d = 1'b0;
                    state_d   = RESP;
                end else if (tmo_expired) begin
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b1;
                    rsp_tmo_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    txn_cnt_d = txn_cnt_q + 16'd1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched command and held response registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            rsp_tmo_q <= 1'b0;
            txn_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
            rsp_tmo_q <= rsp_tmo_d;
            txn_cnt_q <= txn_cnt_d;
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    assign rsp_tmo_o   = rsp_tmo_q;
`else
    assign rsp_tmo_o   = 1'b0;
`endif
    assign txn_cnt_o   = txn_cnt_q;

    // Wishbone outputs are driven only for the duration of the bus cycle.
    assign wb_cyc_o = in_bus;
    assign wb_stb_o = in_bus;
    assign wb_adr_o = in_bus ? adr_q : '0;
    assign wb_dat_o = in_bus ? dat_q : '0;
    assign wb_sel_o = in_bus ? sel_q : '0;
    assign wb_we_o  = in_bus && we_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomised scoreboard bench for wb_cmd_master with a behavioural Wishbone responder.
module tb_wb_cmd_master;
    import wb_cmd_master_pkg::*;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid_i = 1'b0, cmd_ready_o;
    logic [31:0] cmd_adr_i = '0, cmd_dat_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic        cmd_we_i = 1'b0;
    logic        rsp_valid_o, rsp_ready_i = 1'b0;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o, rsp_tmo_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
    logic [15:0] txn_cnt_o;

    wb_cmd_master #(.TIMEOUT_CYCLES(LIMIT)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i), .cmd_we_i(cmd_we_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o), .rsp_tmo_o(rsp_tmo_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .txn_cnt_o(txn_cnt_o)
    );

    // kind: 0 ack, 1 err, 2 ack+err together, 3 responder stays silent
    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          delay;
        int          kind;
        logic [31:0] rdata;
    } txn_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        tmo;
    } rsp_t;

    txn_t        bus_q[$];
    rsp_t        exp_q[$];
    int          accept_cyc[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned model_cnt = 0;
    int          cycle = 0;
    int          rdy_mode = 2;      // 0 random, 1 hold low, 2 always high
    bit          spurious_en = 1'b0;
    int          last_bus_len = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Expected response from the protocol rules: silence or a responder later than the
    // limit ends in a timeout (when compiled in), err beats ack, writes return zero data.
    function automatic rsp_t model(input txn_t t);
        rsp_t r;
        bit   to;
        to = (t.kind == 3);
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        if (t.delay >= LIMIT) to = 1'b1;
`endif
        r.tmo = to;
        r.err = to || (t.kind == 1) || (t.kind == 2);
        r.dat = (r.err || t.we) ? 32'h0 : t.rdata;
        return r;
    endfunction

    function automatic txn_t mk(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                                input logic we, input int delay, input int kind, input logic [31:0] rdata);
        txn_t t;
        t.adr = adr; t.dat = dat; t.sel = sel; t.we = we;
        t.delay = delay; t.kind = kind; t.rdata = rdata;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        int k;
        k = $urandom_range(0, 9);
        return mk($urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 6), (k < 6) ? 0 : ((k < 8) ? 1 : 2), $urandom);
    endfunction

    // Must be entered at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input txn_t t, input bit expect_rsp);
        bit seen;
        int n;
        bus_q.push_back(t);
        if (expect_rsp) exp_q.push_back(model(t));
        cmd_adr_i = t.adr; cmd_dat_i = t.dat; cmd_sel_i = t.sel; cmd_we_i = t.we;
        cmd_valid_i = 1'b1;
        seen = 1'b0;
        for (n = 0; n < 2000 && !seen; n++) begin
            seen = cmd_ready_o;
            if (seen) accept_cyc.push_back(cycle);
            @(negedge clk);
        end
        if (!seen) fail_now("cmd_accept_timeout");
        cmd_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus_q.size() != 0 || rsp_valid_o || wb_cyc_o || cmd_valid_i) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now("drain_timeout");
    endtask

    task automatic wait_rsp_valid();
        int n;
        n = 0;
        while (!rsp_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid_o) fail_now("rsp_valid_wait_timeout");
    endtask

    // Behavioural Wishbone responder: checks the initiator fields and answers per item.
    initial begin
        txn_t cur;
        bit   active;
        int   cnt;
        active = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_dat_i = $urandom;
            if (!rst_n) begin
                active = 1'b0;
                continue;
            end
            if (wb_cyc_o) begin
                if (!active) begin
                    if (bus_q.size() == 0) begin
                        fail_now("unexpected_bus_cycle");
                        continue;
                    end
                    cur = bus_q.pop_front();
                    active = 1'b1;
                    cnt = 0;
                end
                check("wb_adr", wb_adr_o, cur.adr);
                check("wb_dat", wb_dat_o, cur.dat);
                check("wb_sel", 32'(wb_sel_o), 32'(cur.sel));
                check("wb_we", 32'(wb_we_o), 32'(cur.we));
                check("wb_stb", 32'(wb_stb_o), 32'd1);
                if (cnt == cur.delay && cur.kind != 3) begin
                    wb_ack_i = (cur.kind == 0) || (cur.kind == 2);
                    wb_err_i = (cur.kind == 1) || (cur.kind == 2);
                    wb_dat_i = cur.rdata;
                end
                cnt++;
            end else begin
                if (active) last_bus_len = cnt;
                active = 1'b0;
                check("idle_stb", 32'(wb_stb_o), 32'd0);
                check("idle_adr", wb_adr_o, 32'd0);
                check("idle_dat", wb_dat_o, 32'd0);
                check("idle_sel_we", 32'({wb_sel_o, wb_we_o}), 32'd0);
                // Stray returns outside a bus cycle must have no effect.
                if (spurious_en && $urandom_range(0, 3) == 0) begin
                    wb_ack_i = 1'b1;
                    wb_err_i = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Response monitor: compares every presented response against the scoreboard head.
    initial begin
        bit rdy;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rsp_ready_i = 1'b0;
                continue;
            end
            check("txn_cnt", 32'(txn_cnt_o), model_cnt & 32'hFFFF);
            rdy = (rdy_mode == 2) || (rdy_mode == 0 && $urandom_range(0, 1) == 1);
            if (rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_rsp_valid");
                end else begin
                    check("rsp_dat", rsp_dat_o, exp_q[0].dat);
                    check("rsp_err", 32'(rsp_err_o), 32'(exp_q[0].err));
                    check("rsp_tmo", 32'(rsp_tmo_o), 32'(exp_q[0].tmo));
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        model_cnt = (model_cnt + 1) & 32'hFFFF;
                    end
                end
            end
            rsp_ready_i = rdy;
        end
    end

    initial begin
        txn_t t;
        #12;
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_cyc_stb", 32'({wb_cyc_o, wb_stb_o}), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_fields", 32'({rsp_err_o, rsp_tmo_o}), 32'd0);
        check("rst_rsp_dat", rsp_dat_o, 32'd0);
        check("rst_txn_cnt", 32'(txn_cnt_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Write, responder acks one cycle into the bus cycle.
        send(mk(32'h4, 32'hDEADBEEF, 4'hF, 1'b1, 1, 0, 32'hA5A5A5A5), 1'b1);
        drain();
        check("write_txn_cnt", 32'(txn_cnt_o), 32'd1);

        // Read with data held while the consumer stalls.
        rdy_mode = 1;
        send(mk(32'h0, 32'h0, 4'hF, 1'b0, 0, 0, 32'h12345678), 1'b1);
        wait_rsp_valid();
        repeat (5) @(negedge clk);
        check("read_held_dat", rsp_dat_o, 32'h12345678);
        rdy_mode = 2;
        drain();

        // ack and err together.
        send(mk(32'h8, 32'h0, 4'h3, 1'b0, 2, 2, 32'hCAFEF00D), 1'b1);
        drain();

`ifdef WB_CMD_MASTER_TIMEOUT_EN
        // Silent responder ends in a timeout after exactly LIMIT bus cycles.
        send(mk(32'hC, 32'h0, 4'hF, 1'b0, 0, 3, 32'h0), 1'b1);
        drain();
        check("timeout_bus_len", 32'(last_bus_len), 32'(LIMIT));
        // ack in the very cycle the limit is reached wins.
        send(mk(32'h10, 32'h0, 4'hF, 1'b0, LIMIT - 1, 0, 32'h0BADF00D), 1'b1);
        drain();
        check("late_ack_bus_len", 32'(last_bus_len), 32'(LIMIT));
`endif

        // Reset in the middle of a bus cycle abandons it with no response.
        send(mk(32'h14, 32'h55, 4'h1, 1'b1, 0, 3, 32'h0), 1'b0);
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        repeat (1) begin
`else
        repeat (100) begin
`endif
            check("cyc_held", 32'(wb_cyc_o), 32'd1);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cyc_stb", 32'({wb_cyc_o, wb_stb_o}), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("midrst_txn_cnt", 32'(txn_cnt_o), 32'd0);
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("post_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
            check("post_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        end
        @(negedge clk);

        // Back-to-back zero-wait transactions: one per three cycles.
        accept_cyc.delete();
        for (int i = 0; i < 6; i++) begin
            t = rand_txn();
            t.delay = 0;
            t.kind = 0;
            send(t, 1'b1);
        end
        drain();
        for (int i = 1; i < accept_cyc.size(); i++)
            check("throughput_gap", 32'(accept_cyc[i] - accept_cyc[i-1]), 32'd3);

        // Counter wrap with a stalled consumer and a pending second command.
        @(negedge clk);
        #1 force dut.txn_cnt_q = 16'hFFFF;
        model_cnt = 32'hFFFF;
        #1 release dut.txn_cnt_q;
        @(negedge clk);
        rdy_mode = 1;
        send(mk(32'h20, 32'h0, 4'hF, 1'b0, 0, 0, 32'h600DCAFE), 1'b1);
        wait_rsp_valid();
        fork
            send(mk(32'h24, 32'h77, 4'hC, 1'b1, 1, 0, 32'h0), 1'b1);
        join_none
        repeat (10) begin
            @(negedge clk);
            check("stall_cmd_ready", 32'(cmd_ready_o), 32'd0);
            check("stall_rsp_dat", rsp_dat_o, 32'h600DCAFE);
        end
        rdy_mode = 2;
        drain();
        check("wrap_txn_cnt", 32'(txn_cnt_o), 32'd1);

        // Randomised traffic with random consumer stalls and stray responder returns.
        rdy_mode = 0;
        spurious_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send(rand_txn(), 1'b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        rdy_mode = 2;
        drain();
        spurious_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles in a bus cycle before abort (1..65535).
REQ-002 SHALL have clock wb_clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have reset wb_rst_ni, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have cmd_valid_i in 1, cmd_ready_o out 1: command handshake.
REQ-005 SHALL have cmd_adr_i in 32, cmd_dat_i in 32, cmd_sel_i in 4, cmd_we_i in 1: command payload.
REQ-006 SHALL have rsp_valid_o out 1, rsp_ready_i in 1: response handshake.
REQ-007 SHALL have rsp_dat_o out 32, rsp_err_o out 1, rsp_tmo_o out 1: read data, bus error, timeout flag.
REQ-008 SHALL have wb_adr_o out 32, wb_dat_o out 32, wb_sel_o out 4, wb_we_o out 1, wb_cyc_o out 1, wb_stb_o out 1: Wishbone initiator outputs.
REQ-009 SHALL have wb_dat_i in 32, wb_ack_i in 1, wb_err_i in 1: Wishbone responder returns.
REQ-010 SHALL have txn_cnt_o out 16: count of completed transactions, any outcome.

Function
REQ-011 SHALL implement states IDLE, BUS, RESP.
REQ-012 cmd_ready_o SHALL equal (state==IDLE), combinational from state only.
REQ-013 IDLE: on cmd_valid_i&cmd_ready_o at edge N, SHALL latch payload and enter BUS; wb_cyc_o=wb_stb_o=1 after edge N.
REQ-014 BUS: wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o SHALL stay constant; outside BUS all Wishbone outputs SHALL be 0.
REQ-015 BUS: wb_ack_i=1 SHALL, at that edge, drop cyc/stb, capture rsp_dat_o=wb_dat_i for reads (0 for writes), rsp_err_o=0, rsp_tmo_o=0, enter RESP.
REQ-016 BUS: wb_err_i=1 SHALL end the cycle as REQ-015 but rsp_err_o=1, rsp_dat_o=0.
REQ-017 ack and err same cycle: err SHALL win.
REQ-018 Timeout counter SHALL clear on BUS entry, increment each BUS cycle; on reaching TIMEOUT_CYCLES with no ack/err SHALL end the cycle with rsp_err_o=1, rsp_tmo_o=1, rsp_dat_o=0.
REQ-019 ack/err in the same cycle the counter reaches TIMEOUT_CYCLES: ack/err SHALL win, no timeout.
REQ-020 RESP: rsp_valid_o=1 and response fields held until rsp_valid_o&rsp_ready_i; then IDLE next edge.
REQ-021 txn_cnt_o SHALL increment by 1 on each RESP handshake, wrapping 0xFFFF->0x0000.
REQ-022 ack/err seen in IDLE or RESP SHALL be ignored.
REQ-023 Minimum throughput: one transaction per 3 cycles (accept, ack, response).

Reset
REQ-024 wb_rst_ni low SHALL immediately force IDLE, all outputs 0 except cmd_ready_o=1, counters 0, including mid-BUS (cycle abandoned, no response).

Configuration
REQ-025 With WB_CMD_MASTER_TIMEOUT_EN defined, REQ-018/019 timeout logic SHALL be compiled in.
REQ-026 Without it, BUS SHALL wait indefinitely for ack/err, rsp_tmo_o SHALL be constant 0, TIMEOUT_CYCLES ignored.

Structure
REQ-027 Package wb_cmd_master_pkg SHALL hold the state enum, WB_AW=32/WB_DW=32/WB_SW=4 width constants, default TIMEOUT_CYCLES.
REQ-028 Timeout counter SHALL be sub-module wb_tmo_counter (clear, enable, limit in; expired out), instantiated only under WB_CMD_MASTER_TIMEOUT_EN.

Verification
REQ-029 Write adr=0x04 dat=0xDEADBEEF sel=0xF, responder acks 1 cycle later -> wb_we_o=1 and fields stable while cyc; rsp_err_o=0; txn_cnt_o=1.
REQ-030 Read adr=0x00, responder returns 0x12345678 with ack -> rsp_dat_o=0x12345678 held until rsp_ready_i.
REQ-031 Read with wb_ack_i and wb_err_i both high -> rsp_err_o=1, rsp_dat_o=0.
REQ-032 TIMEOUT_CYCLES=4, no ack -> cyc drops after 4 BUS cycles, rsp_err_o=1, rsp_tmo_o=1; without macro, cyc stays high 100 cycles.
REQ-033 Assert wb_rst_ni low mid-BUS -> cyc/stb 0 immediately, no rsp_valid_o, cmd_ready_o=1 after release.
REQ-034 Hold rsp_ready_i=0 10 cycles, new cmd_valid_i -> cmd_ready_o=0, response stable; txn_cnt_o at 0xFFFF wraps to 0.
